// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared defaults and state type for the CRC sequencer
package crc_pkg;

    localparam int WCODE_DEF = 4;
    localparam int WPOLY_DEF = 4;
    localparam int WLEN_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/crc_eval.sv
// rtl/crc_eval.sv - combinational remainder of (data * x^(WPOLY-1) + crc_in * x^WCODE) mod poly
module crc_eval #(
    parameter int WCODE = 4,
    parameter int WPOLY = 4
) (
    input  logic [WCODE-1:0] data,
    input  logic [WPOLY-1:0] poly,
    input  logic [WPOLY-2:0] crc_in,
    output logic [WPOLY-2:0] crc
);

    logic [WPOLY-1:0] acc;
    logic [WPOLY-2:0] r;

    // One long-division step per data bit, MSB first; leading poly term clears the top bit.
    always_comb begin
        r   = crc_in;
        acc = '0;
        for (int i = WCODE - 1; i >= 0; i--) begin
            acc            = {r, 1'b0};
            acc[WPOLY-1]   = acc[WPOLY-1] ^ data[i];
            if (acc[WPOLY-1]) begin
                acc = acc ^ poly;
            end
            r = acc[WPOLY-2:0];
        end
        crc = r;
    end

endmodule

// File: rtl/crc_seq_ctrl.sv
// rtl/crc_seq_ctrl.sv - sequences a multi-word message through crc_eval, one word per cycle
module crc_seq_ctrl
    import crc_pkg::*;
#(
    parameter int WCODE = WCODE_DEF,
    parameter int WPOLY = WPOLY_DEF,
    parameter int WLEN  = WLEN_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WLEN-1:0]  i_len,
    input  logic [WPOLY-1:0] i_poly,
    input  logic [WPOLY-2:0] i_ref,
    input  logic [WCODE-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WPOLY-2:0] o_crc,
    output logic             o_match
);

    state_t           state;
    state_t           state_next;
    logic [WLEN-1:0]  cnt;
    logic [WPOLY-1:0] poly_q;
    logic [WPOLY-2:0] ref_q;
    logic [WPOLY-2:0] rem;
    logic [WPOLY-2:0] rem_next;
    logic [WPOLY-2:0] crc_q;
    logic             match_q;
    logic [WCODE-1:0] word_in;
    logic             start_ok;
    logic             accept;
    logic             last_word;

    assign start_ok  = (state == ST_IDLE) && i_start;
    assign accept    = (state == ST_RUN) && i_valid;
    assign last_word = accept && (cnt == WLEN'(1));

    // Running remainder is folded into the top of the incoming word.
    assign word_in = i_data ^ (WCODE'(rem) << (WCODE - WPOLY + 1));

    crc_eval #(
        .WCODE(WCODE),
        .WPOLY(WPOLY)
    ) u_crc_eval (
        .data   (word_in),
        .poly   (poly_q),
        .crc_in ('0),
        .crc    (rem_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = (i_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_word) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Result registers load on entry to DONE so they are valid while o_done is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            poly_q  <= '0;
            ref_q   <= '0;
            rem     <= '0;
            crc_q   <= '0;
            match_q <= 1'b0;
        end else if (start_ok) begin
            cnt    <= i_len;
            poly_q <= i_poly;
            ref_q  <= i_ref;
            rem    <= '0;
            if (i_len == '0) begin
                crc_q   <= '0;
                match_q <= (i_ref == '0);
            end
        end else if (accept) begin
            cnt <= cnt - WLEN'(1);
            rem <= rem_next;
            if (last_word) begin
                crc_q   <= rem_next;
                match_q <= (rem_next == ref_q);
            end
        end
    end

    assign o_ready = (state == ST_RUN);
    assign o_busy  = (state != ST_IDLE);
    assign o_done  = (state == ST_DONE);
    assign o_crc   = crc_q;
    assign o_match = match_q;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// tb/tb_crc_seq_ctrl.sv - scoreboard bench for crc_seq_ctrl with a long-division reference model
module tb_crc_seq_ctrl;

    localparam int WC = 4;
    localparam int WP = 4;
    localparam int WL = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [WL-1:0] i_len;
    logic [WP-1:0] i_poly;
    logic [WP-2:0] i_ref;
    logic [WC-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          o_busy;
    logic          o_done;
    logic [WP-2:0] o_crc;
    logic          o_match;

    int total = 0;
    int bad   = 0;

    logic [WP-1:0] exp_q [$];
    logic [WC-1:0] words [16];

    crc_seq_ctrl #(.WCODE(WC), .WPOLY(WP), .WLEN(WL)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_len   (i_len),
        .i_poly  (i_poly),
        .i_ref   (i_ref),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_crc   (o_crc),
        .o_match (o_match)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Polynomial long division of the whole bit string M followed by WP-1 zero bits.
    function automatic logic [WP-2:0] model_crc(input int len, input logic [WP-1:0] poly);
        logic [WP-1:0] acc;
        bit            bits [$];
        acc = '0;
        for (int k = 0; k < len; k++)
            for (int b = WC - 1; b >= 0; b--) bits.push_back(words[k][b]);
        for (int z = 0; z < WP - 1; z++) bits.push_back(1'b0);
        foreach (bits[n]) begin
            acc = {acc[WP-2:0], bits[n]};
            if (acc[WP-1]) acc = acc ^ poly;
        end
        return acc[WP-2:0];
    endfunction

    // Monitor: every o_done must correspond to the oldest queued expectation.
    always @(negedge i_clk) begin
        if (i_rst_n && o_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=%0h required=none", {o_match, o_crc});
            end else begin
                logic [WP-1:0] e;
                e = exp_q.pop_front();
                total++;
                if ({o_match, o_crc} !== e) begin
                    bad++;
                    $display("FAIL result {match,crc} actual=%0h required=%0h", {o_match, o_crc}, e);
                end
            end
        end
    end

    task automatic send_msg(input int len, input logic [WP-1:0] poly, input logic [WP-2:0] rv,
                            input logic [WP-2:0] exp_crc, input int gap_max, input bit poke);
        int gap;
        exp_q.push_back({(exp_crc == rv), exp_crc});
        @(posedge i_clk) #1;
        i_start = 1'b1; i_len = WL'(len); i_poly = poly; i_ref = rv;
        @(posedge i_clk) #1;
        i_start = 1'b0; i_len = WL'($urandom); i_poly = WP'($urandom); i_ref = (WP-1)'($urandom);
        if (len == 0) begin
            check("len0_done", o_done, 1);
            check("len0_not_ready", o_ready, 0);
        end
        for (int k = 0; k < len; k++) begin
            gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int g = 0; g < gap; g++) begin
                i_valid = 1'b0;
                i_data  = WC'($urandom);
                if (poke && $urandom_range(0, 1) == 1) begin
                    i_start = 1'b1; i_poly = WP'($urandom); i_len = WL'($urandom);
                end
                check("ready_in_gap", o_ready, 1);
                @(posedge i_clk) #1;
                i_start = 1'b0;
            end
            check("ready_run", o_ready, 1);
            i_valid = 1'b1;
            i_data  = words[k];
            @(posedge i_clk) #1;
            i_valid = 1'b0;
            i_data  = WC'($urandom);
            if (k == len - 1) check("done_latency", o_done, 1);
            else              check("no_early_done", o_done, 0);
        end
        @(posedge i_clk) #1;
        check("idle_busy", o_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WP-1:0] p;
        logic [WP-2:0] e;
        logic [WP-2:0] rv;
        int            len;

        i_rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_poly = '0;
        i_ref = '0; i_data = '0; i_valid = 1'b0;
        #12;
        check("rst_busy",  o_busy,  0);
        check("rst_ready", o_ready, 0);
        check("rst_done",  o_done,  0);
        check("rst_crc",   o_crc,   0);
        check("rst_match", o_match, 0);
        i_rst_n = 1'b1;

        words[0] = 4'b1101;
        send_msg(1, 4'b1011, 3'b001, 3'b001, 0, 1'b0);
        words[0] = 4'b1101; words[1] = 4'b0000;
        exp_q.push_back({1'b0, 3'b110});
        @(posedge i_clk) #1;
        i_start = 1'b1; i_len = 4'd2; i_poly = 4'b1011; i_ref = 3'b000;
        @(posedge i_clk) #1;
        i_start = 1'b0;
        i_valid = 1'b1; i_data = 4'b1101;
        @(posedge i_clk) #1;
        i_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check("ready_hold", o_ready, 1);
            @(posedge i_clk) #1;
        end
        i_valid = 1'b1; i_data = 4'b0000;
        @(posedge i_clk) #1;
        i_valid = 1'b0;
        check("gap_done_latency", o_done, 1);
        @(posedge i_clk) #1;

        words[0] = 4'b1000;
        send_msg(1, 4'b1011, 3'b000, 3'b101, 0, 1'b0);
        send_msg(0, 4'b1011, 3'b000, 3'b000, 0, 1'b0);
        words[0] = 4'b1000;
        send_msg(1, 4'b1011, 3'b000, 3'b101, 0, 1'b0);

        // Abort mid-message with reset; the aborted message must never report.
        @(posedge i_clk) #1;
        i_start = 1'b1; i_len = 4'd2; i_poly = 4'b1011; i_ref = 3'b001;
        @(posedge i_clk) #1;
        i_start = 1'b0; i_valid = 1'b1; i_data = 4'b0110;
        @(posedge i_clk) #1;
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  o_busy,  0);
        check("mid_rst_ready", o_ready, 0);
        check("mid_rst_done",  o_done,  0);
        check("mid_rst_crc",   o_crc,   0);
        check("mid_rst_match", o_match, 0);
        i_valid = 1'b1; i_data = 4'b1111;
        repeat (3) @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        words[0] = 4'b1101;
        send_msg(1, 4'b1011, 3'b001, 3'b001, 0, 1'b0);

        words[0] = 4'b1101; words[1] = 4'b0000;
        send_msg(2, 4'b1011, 3'b110, 3'b110, 3, 1'b1);

        for (int m = 0; m < 40; m++) begin
            len = (m == 0) ? 15 : $urandom_range(0, 15);
            p   = WP'($urandom);
            p[WP-1] = 1'b1;
            for (int k = 0; k < 16; k++) words[k] = WC'($urandom);
            e  = model_crc(len, p);
            rv = ($urandom_range(0, 1) == 1) ? e : (WP-1)'($urandom);
            send_msg(len, p, rv, e, 2, 1'b1);
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                i_valid = 1'b1;
                i_data  = WC'($urandom);
                @(posedge i_clk) #1;
                check("idle_ignores_valid", o_busy, 0);
            end
            i_valid = 1'b0;
        end

        repeat (3) @(posedge i_clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
